// File: rtl/ahb_mem_arbiter_if.sv
// Request/grant ports of both masters plus the AHB slave-side signals.
// The arbiter connects through 'master' (it masters the AHB slave); the environment uses 'slave'.
interface ahb_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  m0_req, m1_req;
  logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
  logic                  m0_write, m1_write;
  logic [LEN_WIDTH-1:0]  m0_len, m1_len;
  logic [DATA_WIDTH-1:0] m0_wdata, m1_wdata;
  logic                  m0_gnt, m1_gnt;
  logic                  m0_beat, m1_beat;
  logic                  m0_rvalid, m1_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
  logic                  m0_done, m1_done;
  logic                  m0_err, m1_err;
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_write, m1_write,
           m0_len, m1_len, m0_wdata, m1_wdata, HRDATA, HREADY, HRESP,
    output m0_gnt, m1_gnt, m0_beat, m1_beat, m0_rvalid, m1_rvalid,
           m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err,
           HSEL, HADDR, HTRANS, HWRITE, HWDATA
  );

  modport slave (
    output m0_req, m1_req, m0_addr, m1_addr, m0_write, m1_write,
           m0_len, m1_len, m0_wdata, m1_wdata, HRDATA, HREADY, HRESP,
    input  m0_gnt, m1_gnt, m0_beat, m1_beat, m0_rvalid, m1_rvalid,
           m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err,
           HSEL, HADDR, HTRANS, HWRITE, HWDATA
  );
endinterface

// File: rtl/ahb_mem_arbiter.sv
// Two-master round-robin arbiter that sequences single/incrementing bursts onto the
// AHB memory slave one beat at a time (ADDR then DATA), with wait-state timeout.
module ahb_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_mem_arbiter_if.master bus
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 gnt_q, gnt_d;
  logic [1:0]                 beat_q, beat_d;
  logic [1:0]                 rvalid_q, rvalid_d;
  logic [1:0]                 done_q, done_d;
  logic [1:0]                 err_q, err_d;
  logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                       owner_q, owner_d;
  logic                       last_q, last_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       write_q, write_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic [WW-1:0]              wait_q, wait_d;
  logic                       hsel_q, hsel_d;
  logic [1:0]                 htrans_q, htrans_d;
  logic [DATA_WIDTH-1:0]      hwdata_q, hwdata_d;

  logic [1:0]                 req;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0]                 req_write;
  logic [1:0][LEN_WIDTH-1:0]  req_len;
  logic [1:0][DATA_WIDTH-1:0] req_wdata;
  logic                       win;

  assign req       = {bus.m1_req, bus.m0_req};
  assign req_addr  = {bus.m1_addr, bus.m0_addr};
  assign req_write = {bus.m1_write, bus.m0_write};
  assign req_len   = {bus.m1_len, bus.m0_len};
  assign req_wdata = {bus.m1_wdata, bus.m0_wdata};

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    beat_d   = '0;
    rvalid_d = '0;
    done_d   = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    write_d  = write_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    hsel_d   = hsel_q;
    htrans_d = HT_IDLE;
    hwdata_d = hwdata_q;
    win      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // On a tie the master that did not own the previous transaction wins.
          win          = (req[0] & req[1]) ? ~last_q : req[1];
          owner_d      = win;
          addr_d       = req_addr[win];
          write_d      = req_write[win];
          len_d        = req_len[win];
          cnt_d        = '0;
          wait_d       = '0;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          hsel_d       = 1'b1;
          htrans_d     = HT_NONSEQ;
          state_d      = S_ADDR;
        end
      end

      S_ADDR: begin
        hwdata_d = req_wdata[owner_q];
        state_d  = S_DATA;
      end

      S_DATA: begin
        if (bus.HREADY) begin
          if (bus.HRESP) begin
            err_d[owner_q]  = 1'b1;
            done_d[owner_q] = 1'b1;
            gnt_d           = '0;
            hsel_d          = 1'b0;
            state_d         = S_DONE;
          end else begin
            beat_d[owner_q] = 1'b1;
            if (!write_q) begin
              rvalid_d[owner_q] = 1'b1;
              rdata_d[owner_q]  = bus.HRDATA;
            end
            if (cnt_q == len_q) begin
              done_d[owner_q] = 1'b1;
              gnt_d           = '0;
              hsel_d          = 1'b0;
              state_d         = S_DONE;
            end else begin
              // Address wraps naturally at the top of the slave's word space.
              cnt_d    = cnt_q + LEN_WIDTH'(1);
              addr_d   = addr_q + ADDR_WIDTH'(1);
              wait_d   = '0;
              htrans_d = HT_SEQ;
              state_d  = S_ADDR;
            end
          end
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          err_d[owner_q]  = 1'b1;
          done_d[owner_q] = 1'b1;
          gnt_d           = '0;
          hsel_d          = 1'b0;
          state_d         = S_DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      beat_q   <= '0;
      rvalid_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      write_q  <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      hsel_q   <= 1'b0;
      htrans_q <= HT_IDLE;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      hsel_q   <= hsel_d;
      htrans_q <= htrans_d;
      hwdata_q <= hwdata_d;
    end
  end

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_beat   = beat_q[0];
  assign bus.m1_beat   = beat_q[1];
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.m0_done   = done_q[0];
  assign bus.m1_done   = done_q[1];
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
  assign bus.HSEL      = hsel_q;
  assign bus.HADDR     = addr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = write_q;
  assign bus.HWDATA    = hwdata_q;
endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter: a table of single-master transactions plus
// hand sequences for ties, slave error hand-off and mid-burst reset.
module tb_ahb_mem_arbiter;
  logic HCLK = 1'b0;
  logic HRESET = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_mem_arbiter_if b();
  ahb_mem_arbiter dut (.HCLK(HCLK), .HRESET(HRESET), .bus(b));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             m;
    logic             wr;
    logic [9:0]       addr;
    logic [3:0]       len;
    logic [31:0]      wd;
    logic [31:0]      rd;
    int               waits;
    int               errb;
    logic [3:0][9:0]  ea;
    int               ebeats;
    logic             eerr;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_m(input logic m, input logic rq, input logic [9:0] a,
                         input logic wr, input logic [3:0] l, input logic [31:0] wd);
    if (m) begin
      b.m1_req = rq; b.m1_addr = a; b.m1_write = wr; b.m1_len = l; b.m1_wdata = wd;
    end else begin
      b.m0_req = rq; b.m0_addr = a; b.m0_write = wr; b.m0_len = l; b.m0_wdata = wd;
    end
  endtask

  // Runs one record; called just after a negedge with the arbiter idle.
  task automatic run_rec(input vec_t r);
    int aidx = 0, wcnt = 0, beats = 0, rv = 0, bi;
    logic got_done = 1'b0;
    logic [31:0] wd = r.wd;
    logic [1:0] ai;
    logic g, bt, rvld, dn, er;
    logic [31:0] rd;
    drive_m(r.m, 1'b1, r.addr, r.wr, r.len, wd);
    @(negedge HCLK);
    chk("gnt_latency", r.m ? b.m1_gnt : b.m0_gnt, 1'b1);
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      g    = r.m ? b.m1_gnt    : b.m0_gnt;
      bt   = r.m ? b.m1_beat   : b.m0_beat;
      rvld = r.m ? b.m1_rvalid : b.m0_rvalid;
      dn   = r.m ? b.m1_done   : b.m0_done;
      er   = r.m ? b.m1_err    : b.m0_err;
      rd   = r.m ? b.m1_rdata  : b.m0_rdata;
      chk("gnt_overlap", b.m0_gnt & b.m1_gnt, 1'b0);
      if (bt) begin
        beats++;
        wd = wd + 32'd1;
        drive_m(r.m, 1'b1, r.addr, r.wr, r.len, wd);
      end
      if (rvld) begin
        chk("rdata", rd, r.rd + 32'(rv));
        rv++;
      end
      if (dn) begin
        got_done = 1'b1;
        chk("err", er, r.eerr);
        chk("beats", beats, r.ebeats);
        chk("gnt_low_in_done", g, 1'b0);
        drive_m(r.m, 1'b0, r.addr, r.wr, r.len, wd);
      end else if (b.HTRANS != 2'b00) begin
        ai = 2'(aidx);
        if (aidx < 4) chk("haddr", b.HADDR, r.ea[ai]);
        chk("htrans", b.HTRANS, (aidx == 0) ? 2'b10 : 2'b11);
        chk("hwrite", b.HWRITE, r.wr);
        aidx++;
        wcnt = 0;
      end else if (b.HSEL) begin
        bi = aidx - 1;
        if (r.wr) chk("hwdata", b.HWDATA, r.wd + 32'(bi));
        if (bi == 0 && wcnt < r.waits) begin
          b.HREADY = 1'b0;
          wcnt++;
        end else begin
          b.HREADY = 1'b1;
          b.HRESP  = (bi == r.errb);
          b.HRDATA = r.rd + 32'(bi);
        end
      end
      if (!got_done) @(negedge HCLK);
    end
    if (!got_done) chk("done_timeout", 1'b0, 1'b1);
    b.HREADY = 1'b1;
    b.HRESP  = 1'b0;
    @(negedge HCLK);
  endtask

  // Both masters request together; m0 may get slave errors. Reports grant order.
  task automatic run_pair(input logic errm0, input logic [9:0] a0, input logic [3:0] l0,
                          output int first_g, output int second_g,
                          output int err0, output int err1, output int beats0);
    logic pend0 = 1'b1, pend1 = 1'b1, prev0 = 1'b0, prev1 = 1'b0;
    first_g = -1; second_g = -1; err0 = -1; err1 = -1; beats0 = 0;
    drive_m(1'b0, 1'b1, a0, 1'b1, l0, 32'hCAFE0000);
    drive_m(1'b1, 1'b1, 10'h200, 1'b0, 4'd0, 32'h0);
    for (int cyc = 0; cyc < 100 && (pend0 || pend1); cyc++) begin
      @(negedge HCLK);
      chk("pair_overlap", b.m0_gnt & b.m1_gnt, 1'b0);
      if (b.m0_gnt && !prev0) begin
        if (first_g < 0) first_g = 0; else second_g = 0;
      end
      if (b.m1_gnt && !prev1) begin
        if (first_g < 0) first_g = 1; else second_g = 1;
      end
      prev0 = b.m0_gnt;
      prev1 = b.m1_gnt;
      if (b.m0_beat) beats0++;
      if (b.m0_done) begin err0 = int'(b.m0_err); b.m0_req = 1'b0; pend0 = 1'b0; end
      if (b.m1_done) begin err1 = int'(b.m1_err); b.m1_req = 1'b0; pend1 = 1'b0; end
      b.HREADY = 1'b1;
      b.HRESP  = errm0 & b.m0_gnt & b.HSEL & (b.HTRANS == 2'b00);
      b.HRDATA = 32'h0000_5A5A;
    end
    if (pend0 || pend1) chk("pair_timeout", 1'b0, 1'b1);
    b.HRESP = 1'b0;
    @(negedge HCLK);
  endtask

  initial begin
    int f, s, e0, e1, bt0, rbeats;
    logic seen_dn;

    tbl[0] = '{m:1'b0, wr:1'b1, addr:10'h010, len:4'd0, wd:32'hDEADBEEF, rd:32'h0,
               waits:0, errb:15, ea:{10'h0, 10'h0, 10'h0, 10'h010}, ebeats:1, eerr:1'b0};
    tbl[1] = '{m:1'b1, wr:1'b0, addr:10'h3FE, len:4'd3, wd:32'h0, rd:32'h1,
               waits:0, errb:15, ea:{10'h001, 10'h000, 10'h3FF, 10'h3FE}, ebeats:4, eerr:1'b0};
    tbl[2] = '{m:1'b1, wr:1'b0, addr:10'h100, len:4'd0, wd:32'h0, rd:32'h77,
               waits:16, errb:15, ea:{10'h0, 10'h0, 10'h0, 10'h100}, ebeats:0, eerr:1'b1};
    tbl[3] = '{m:1'b1, wr:1'b0, addr:10'h101, len:4'd0, wd:32'h0, rd:32'hA5,
               waits:15, errb:15, ea:{10'h0, 10'h0, 10'h0, 10'h101}, ebeats:1, eerr:1'b0};
    tbl[4] = '{m:1'b0, wr:1'b1, addr:10'h020, len:4'd1, wd:32'h11110000, rd:32'h0,
               waits:2, errb:15, ea:{10'h0, 10'h0, 10'h021, 10'h020}, ebeats:2, eerr:1'b0};

    drive_m(1'b0, 1'b0, 10'h0, 1'b0, 4'd0, 32'h0);
    drive_m(1'b1, 1'b0, 10'h0, 1'b0, 4'd0, 32'h0);
    b.HRDATA = 32'h0; b.HREADY = 1'b1; b.HRESP = 1'b0;

    #1 HRESET = 1'b1;
    @(negedge HCLK);
    chk("rst_gnt", {b.m1_gnt, b.m0_gnt}, 2'b00);
    chk("rst_pulses", {b.m0_beat, b.m1_beat, b.m0_rvalid, b.m1_rvalid,
                       b.m0_done, b.m1_done, b.m0_err, b.m1_err}, 8'h00);
    chk("rst_rdata0", b.m0_rdata, 32'h0);
    chk("rst_rdata1", b.m1_rdata, 32'h0);
    chk("rst_ahb_ctl", {b.HSEL, b.HTRANS, b.HWRITE}, 4'h0);
    chk("rst_haddr", b.HADDR, 10'h0);
    chk("rst_hwdata", b.HWDATA, 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);

    for (int i = 0; i < 5; i++) run_rec(tbl[i]);

    // Last owner was m0; a mid-burst reset must restore m0 priority on the next tie.
    drive_m(1'b0, 1'b1, 10'h040, 1'b1, 4'd3, 32'h0BAD0000);
    rbeats = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge HCLK);
      if (b.m0_beat) rbeats++;
      if (b.HSEL && b.HTRANS == 2'b00 && rbeats == 2) begin
        b.HREADY = 1'b0;
        break;
      end
    end
    chk("rst_reached_beat2", rbeats, 2);
    #2 HRESET = 1'b1;
    #1;
    chk("arst_gnt", b.m0_gnt, 1'b0);
    chk("arst_ahb_ctl", {b.HSEL, b.HTRANS, b.HWRITE}, 4'h0);
    chk("arst_haddr", b.HADDR, 10'h0);
    chk("arst_hwdata", b.HWDATA, 32'h0);
    chk("arst_done", {b.m0_done, b.m0_err}, 2'b00);
    b.m0_req = 1'b0;
    b.HREADY = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    seen_dn = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      seen_dn = seen_dn | b.m0_done | b.m1_done;
    end
    chk("no_done_after_rst", seen_dn, 1'b0);

    run_pair(1'b0, 10'h050, 4'd0, f, s, e0, e1, bt0);
    chk("tie1_first", f, 0);
    chk("tie1_second", s, 1);
    run_pair(1'b0, 10'h051, 4'd0, f, s, e0, e1, bt0);
    chk("tie2_first", f, 0);
    chk("tie2_second", s, 1);
    chk("tie2_m0_beats", bt0, 1);

    run_pair(1'b1, 10'h002, 4'd2, f, s, e0, e1, bt0);
    chk("errpair_first", f, 0);
    chk("errpair_m0_err", e0, 1);
    chk("errpair_m0_beats", bt0, 0);
    chk("errpair_second", s, 1);
    chk("errpair_m1_err", e1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
